// File: rtl/md_stall_ctrl.sv
// Multiply/divide issue and stall controller.
// Starts one mult/div operation at a time and holds md_busy for the unit's fixed
// latency. The D stage is frozen while a dependent instruction waits on HI/LO.
module md_stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  E_md_op,
  input  logic        D_md_use,
  input  logic        flush,
  output logic [2:0]  md_start,
  output logic        stall,
  output logic        md_busy,
  output logic [15:0] issue_cnt,
  output logic        err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The busy counter is loaded with latency-1, so BUSY lasts exactly the latency.
  localparam logic [3:0] MULT_INIT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_INIT  = 4'(DIV_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       op_valid;
  logic       op_is_mult;
  logic       issue;

  // Op codes 1..4 are real operations. Codes 5..7 behave like "none".
  assign op_valid   = (E_md_op >= 3'd1) && (E_md_op <= 3'd4);
  assign op_is_mult = (E_md_op == 3'd1) || (E_md_op == 3'd2);

  // rst_n gates issue so that md_start and stall stay low while reset is held,
  // even though E-stage inputs may still carry an op.
  assign issue = rst_n && (state == IDLE) && op_valid && !flush;

  assign md_start = issue ? E_md_op : 3'd0;
  assign stall    = rst_n && D_md_use && ((state == BUSY) || issue);
  assign md_busy  = (state == BUSY);

  // Next-state and counter logic for the IDLE/BUSY controller.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = BUSY;
          cnt_nxt   = op_is_mult ? MULT_INIT : DIV_INIT;
        end
      end
      BUSY: begin
        // A flush does not abort here: the unit has already committed HI/LO.
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and busy-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together from pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Accepted-issue counter and sticky protocol-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= 16'd0;
      err       <= 1'b0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + 16'd1;
      // A new op arriving while busy is a pipeline protocol violation.
      if ((state == BUSY) && op_valid) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed self-checking bench for md_stall_ctrl with default latencies (5 / 10).
module tb_md_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  E_md_op;
  logic        D_md_use;
  logic        flush;
  logic [2:0]  md_start;
  logic        stall;
  logic        md_busy;
  logic [15:0] issue_cnt;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  md_stall_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .E_md_op   (E_md_op),
    .D_md_use  (D_md_use),
    .flush     (flush),
    .md_start  (md_start),
    .stall     (stall),
    .md_busy   (md_busy),
    .issue_cnt (issue_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run through the remaining busy cycles with the current inputs, counting them
  // and recording whether stall was ever seen high or low. Bounded at 40 cycles.
  task automatic run_busy(output int n, output bit saw_hi, output bit saw_lo);
    n      = 0;
    saw_hi = 1'b0;
    saw_lo = 1'b0;
    #1;
    while (md_busy && n < 40) begin
      if (stall) saw_hi = 1'b1;
      else       saw_lo = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    bit hi;
    bit lo;

    // Reset with an op and a dependent instruction present.
    rst_n    = 1'b0;
    E_md_op  = 3'd1;
    D_md_use = 1'b1;
    flush    = 1'b0;
    #2;
    check("rst_busy",  32'(md_busy),   32'd0);
    check("rst_cnt",   32'(issue_cnt), 32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_start", 32'(md_start),  32'd0);
    check("rst_stall", 32'(stall),     32'd0);
    tick();
    tick();
    rst_n    = 1'b1;
    E_md_op  = 3'd0;
    D_md_use = 1'b0;
    #1;

    // Flush blocks a would-be divu issue.
    E_md_op = 3'd4;
    flush   = 1'b1;
    #1;
    check("flush_start", 32'(md_start), 32'd0);
    tick();
    E_md_op = 3'd0;
    flush   = 1'b0;
    #1;
    check("flush_busy", 32'(md_busy),   32'd0);
    check("flush_cnt",  32'(issue_cnt), 32'd0);
    check("flush_err",  32'(err),       32'd0);

    // Single mult without a dependent D instruction.
    E_md_op = 3'd1;
    #1;
    check("mult_start", 32'(md_start), 32'd1);
    check("mult_stall", 32'(stall),    32'd0);
    tick();
    E_md_op = 3'd0;
    run_busy(n, hi, lo);
    check("mult_busy_len",   32'(n),         32'd5);
    check("mult_stall_seen", 32'(hi),        32'd0);
    check("mult_issue_cnt",  32'(issue_cnt), 32'd1);

    // Div with a dependent instruction held in D: stall through all 10 busy cycles.
    D_md_use = 1'b1;
    E_md_op  = 3'd3;
    #1;
    check("div_start", 32'(md_start), 32'd3);
    check("div_stall_issue", 32'(stall), 32'd1);
    tick();
    E_md_op = 3'd0;
    run_busy(n, hi, lo);
    check("div_busy_len",    32'(n),  32'd10);
    check("div_stall_gap",   32'(lo), 32'd0);
    check("div_stall_after", 32'(stall), 32'd0);
    D_md_use = 1'b0;
    check("div_issue_cnt", 32'(issue_cnt), 32'd2);

    // multu arriving on the 3rd busy cycle of a mult: rejected, err set.
    E_md_op = 3'd1;
    #1;
    tick();
    E_md_op = 3'd0;
    tick();
    tick();
    E_md_op = 3'd2;
    #1;
    check("viol_start", 32'(md_start), 32'd0);
    check("viol_busy",  32'(md_busy),  32'd1);
    tick();
    E_md_op = 3'd0;
    run_busy(n, hi, lo);
    check("viol_rest_len",  32'(n),         32'd2);
    check("viol_err",       32'(err),       32'd1);
    check("viol_issue_cnt", 32'(issue_cnt), 32'd3);

    // Flush during busy does not shorten the operation.
    E_md_op = 3'd1;
    #1;
    tick();
    E_md_op = 3'd0;
    flush   = 1'b1;
    run_busy(n, hi, lo);
    flush = 1'b0;
    check("flush_busy_len", 32'(n), 32'd5);

    // Back-to-back: div issues in the first idle cycle after a mult.
    E_md_op = 3'd1;
    #1;
    tick();
    E_md_op = 3'd0;
    run_busy(n, hi, lo);
    check("b2b_mult_len", 32'(n), 32'd5);
    E_md_op = 3'd3;
    #1;
    check("b2b_start", 32'(md_start), 32'd3);
    tick();
    E_md_op = 3'd0;
    run_busy(n, hi, lo);
    check("b2b_div_len",   32'(n),         32'd10);
    check("b2b_issue_cnt", 32'(issue_cnt), 32'd6);
    check("err_sticky",    32'(err),       32'd1);

    // Reset pulse on the 4th busy cycle of a div abandons it.
    E_md_op = 3'd3;
    #1;
    tick();
    E_md_op = 3'd0;
    tick();
    tick();
    tick();
    #1;
    check("rb_busy_before", 32'(md_busy), 32'd1);
    rst_n    = 1'b0;
    E_md_op  = 3'd1;
    D_md_use = 1'b1;
    #1;
    check("rb_busy",  32'(md_busy),   32'd0);
    check("rb_cnt",   32'(issue_cnt), 32'd0);
    check("rb_err",   32'(err),       32'd0);
    check("rb_start", 32'(md_start),  32'd0);
    check("rb_stall", 32'(stall),     32'd0);
    rst_n = 1'b1;
    #1;
    check("rb_reissue_start", 32'(md_start), 32'd1);
    check("rb_reissue_stall", 32'(stall),    32'd1);
    tick();
    E_md_op  = 3'd0;
    D_md_use = 1'b0;
    check("rb_reissue_busy", 32'(md_busy),   32'd1);
    check("rb_reissue_cnt",  32'(issue_cnt), 32'd1);
    run_busy(n, hi, lo);
    check("rb_reissue_len", 32'(n), 32'd5);

    // Issue-counter wrap: preload near the top, then two real issues.
    force dut.issue_cnt = 16'hFFFE;
    #1;
    release dut.issue_cnt;
    #1;
    check("wrap_preload", 32'(issue_cnt), 32'h0000_FFFE);
    E_md_op = 3'd1;
    #1;
    tick();
    E_md_op = 3'd0;
    #1;
    check("wrap_ffff", 32'(issue_cnt), 32'h0000_FFFF);
    run_busy(n, hi, lo);
    E_md_op = 3'd1;
    #1;
    tick();
    E_md_op = 3'd0;
    #1;
    check("wrap_zero", 32'(issue_cnt), 32'h0000_0000);
    run_busy(n, hi, lo);
    check("wrap_busy_len", 32'(n), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
